// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, FSM state encoding and the opcode classifier.
package control_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned NREGS  = 16;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 27;
    localparam int unsigned RA_MSB = 26;
    localparam int unsigned RA_LSB = 23;
    localparam int unsigned RB_MSB = 22;
    localparam int unsigned RB_LSB = 19;
    localparam int unsigned RC_MSB = 18;
    localparam int unsigned RC_LSB = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_BINARY, CLS_WIDE, CLS_UNARY, CLS_HALT, CLS_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   return CLS_BINARY;
            OP_MUL, OP_DIV:                  return CLS_WIDE;
            OP_NEG, OP_NOT:                  return CLS_UNARY;
            OP_HALT:                         return CLS_HALT;
            default:                         return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// Register-number to one-hot strobe decoder with enable.
module reg_decoder_4to16
    import control_pkg::*;
(
    input  logic [REG_W-1:0] sel_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit; outputs are decoded from the state
// register (plus IR fields during execute) so they are valid for the whole cycle.
module control_sequencer
    import control_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic [WORD_W-1:0] IR,
    output logic [NREGS-1:0]  R_rd,
    output logic [NREGS-1:0]  R_wrt,
    output logic              PC_out,
    output logic              MDR_out,
    output logic              Zhi_out,
    output logic              Zlo_out,
    output logic              HI_out,
    output logic              LO_out,
    output logic              PC_rd,
    output logic              MAR_rd,
    output logic              MDR_rd,
    output logic              IR_rd,
    output logic              Y_rd,
    output logic              Zlo_rd,
    output logic              Zhi_rd,
    output logic              HI_rd,
    output logic              LO_rd,
    output logic              IncPC,
    output logic              Read,
    output logic [OP_W-1:0]   op_sel,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    op_class_e         cls;
    logic [OP_W-1:0]   opcode;
    logic [REG_W-1:0]  ra, rb, rc, wrt_sel;
    logic              rd_en, wrt_en;
    state_e            next_instr;
    logic              unused_ir;

    assign opcode     = IR[OP_MSB:OP_LSB];
    assign ra         = IR[RA_MSB:RA_LSB];
    assign rb         = IR[RB_MSB:RB_LSB];
    assign rc         = IR[RC_MSB:RC_LSB];
    assign cls        = op_class(opcode);
    assign next_instr = run ? S_T0 : S_IDLE;
    assign unused_ir  = ^IR[RC_LSB-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The instruction length depends on the opcode class; the last execute
    // state of each class is the point where run is resampled.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (cls == CLS_HALT)         state_d = S_HALT;
                else if (cls == CLS_ILLEGAL) state_d = next_instr;
                else                         state_d = S_T4;
            end
            S_T4:   state_d = (cls == CLS_UNARY)  ? next_instr : S_T5;
            S_T5:   state_d = (cls == CLS_BINARY) ? next_instr : S_T6;
            S_T6:   state_d = next_instr;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PC_out  = 1'b0;
        MDR_out = 1'b0;
        Zhi_out = 1'b0;
        Zlo_out = 1'b0;
        HI_out  = 1'b0;
        LO_out  = 1'b0;
        PC_rd   = 1'b0;
        MAR_rd  = 1'b0;
        MDR_rd  = 1'b0;
        IR_rd   = 1'b0;
        Y_rd    = 1'b0;
        Zlo_rd  = 1'b0;
        Zhi_rd  = 1'b0;
        HI_rd   = 1'b0;
        LO_rd   = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        op_sel  = '0;
        halted  = 1'b0;
        illegal = 1'b0;
        rd_en   = 1'b0;
        wrt_en  = 1'b0;
        case (state_q)
            S_T0: begin
                PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1;
            end
            S_T1: begin
                Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1;
            end
            S_T2: begin
                MDR_out = 1'b1; IR_rd = 1'b1;
            end
            S_T3: begin
                case (cls)
                    CLS_BINARY, CLS_WIDE: begin
                        wrt_en = 1'b1; Y_rd = 1'b1;
                    end
                    CLS_UNARY: begin
                        wrt_en = 1'b1; op_sel = opcode; Zlo_rd = 1'b1;
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                if (cls == CLS_UNARY) begin
                    Zlo_out = 1'b1; rd_en = 1'b1;
                end else begin
                    wrt_en = 1'b1; op_sel = opcode; Zlo_rd = 1'b1;
                    Zhi_rd = (cls == CLS_WIDE);
                end
            end
            S_T5: begin
                Zlo_out = 1'b1;
                if (cls == CLS_WIDE) LO_rd = 1'b1;
                else                 rd_en = 1'b1;
            end
            S_T6: begin
                Zhi_out = 1'b1; HI_rd = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // Source register is rb in T3 and rc in T4.
    assign wrt_sel = (state_q == S_T4) ? rc : rb;

    reg_decoder_4to16 u_rd_dec (
        .sel_i    (ra),
        .en_i     (rd_en),
        .onehot_o (R_rd)
    );

    reg_decoder_4to16 u_wrt_dec (
        .sel_i    (wrt_sel),
        .en_i     (wrt_en),
        .onehot_o (R_wrt)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-instruction schedule model
// built from the opcode class tables, with the bench acting as the datapath.
module tb_control_sequencer;

    typedef struct packed {
        logic [15:0] r_rd;
        logic [15:0] r_wrt;
        logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out;
        logic pc_rd, mar_rd, mdr_rd, ir_rd, y_rd, zlo_rd, zhi_rd, hi_rd, lo_rd;
        logic inc_pc, read;
        logic [4:0] op_sel;
        logic halted, illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        run = 1'b0;
    logic [31:0] IR  = '0;
    logic [15:0] R_rd, R_wrt;
    logic PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out;
    logic PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
    logic IncPC, Read, halted, illegal;
    logic [4:0] op_sel;

    int total = 0;
    int bad   = 0;

    ctl_t        sched[$];
    logic [31:0] directed[$];
    logic [31:0] cur_ir;
    logic        cur_is_halt;
    int          idx;
    int          mode;          // 0 idle, 1 executing an instruction, 2 halted
    int          halt_cycles;
    int          n_instr;

    control_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .IR(IR),
        .R_rd(R_rd), .R_wrt(R_wrt),
        .PC_out(PC_out), .MDR_out(MDR_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .HI_out(HI_out), .LO_out(LO_out),
        .PC_rd(PC_rd), .MAR_rd(MAR_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd),
        .Zlo_rd(Zlo_rd), .Zhi_rd(Zhi_rd), .HI_rd(HI_rd), .LO_rd(LO_rd),
        .IncPC(IncPC), .Read(Read), .op_sel(op_sel),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.r_rd = R_rd;       c.r_wrt = R_wrt;
        c.pc_out = PC_out;   c.mdr_out = MDR_out; c.zhi_out = Zhi_out;
        c.zlo_out = Zlo_out; c.hi_out = HI_out;   c.lo_out = LO_out;
        c.pc_rd = PC_rd;     c.mar_rd = MAR_rd;   c.mdr_rd = MDR_rd;
        c.ir_rd = IR_rd;     c.y_rd = Y_rd;       c.zlo_rd = Zlo_rd;
        c.zhi_rd = Zhi_rd;   c.hi_rd = HI_rd;     c.lo_rd = LO_rd;
        c.inc_pc = IncPC;    c.read = Read;       c.op_sel = op_sel;
        c.halted = halted;   c.illegal = illegal;
        return c;
    endfunction

    function automatic logic [15:0] bit16(input logic [3:0] n);
        return 16'(1) << n;
    endfunction

    // Expected cycle-by-cycle pattern for one whole instruction, T0 onward.
    function automatic void build(input logic [31:0] ir);
        ctl_t c;
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        sched.delete();
        c = '0; c.pc_out = 1; c.mar_rd = 1; c.inc_pc = 1; c.zlo_rd = 1; sched.push_back(c);
        c = '0; c.zlo_out = 1; c.pc_rd = 1; c.read = 1; c.mdr_rd = 1;   sched.push_back(c);
        c = '0; c.mdr_out = 1; c.ir_rd = 1;                               sched.push_back(c);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                c = '0; c.r_wrt = bit16(rb); c.y_rd = 1;                      sched.push_back(c);
                c = '0; c.r_wrt = bit16(rc); c.op_sel = op; c.zlo_rd = 1;     sched.push_back(c);
                c = '0; c.zlo_out = 1; c.r_rd = bit16(ra);                    sched.push_back(c);
            end
            5'd15, 5'd16: begin
                c = '0; c.r_wrt = bit16(rb); c.y_rd = 1;                      sched.push_back(c);
                c = '0; c.r_wrt = bit16(rc); c.op_sel = op; c.zlo_rd = 1; c.zhi_rd = 1;
                sched.push_back(c);
                c = '0; c.zlo_out = 1; c.lo_rd = 1;                           sched.push_back(c);
                c = '0; c.zhi_out = 1; c.hi_rd = 1;                           sched.push_back(c);
            end
            5'd17, 5'd18: begin
                c = '0; c.r_wrt = bit16(rb); c.op_sel = op; c.zlo_rd = 1;     sched.push_back(c);
                c = '0; c.zlo_out = 1; c.r_rd = bit16(ra);                    sched.push_back(c);
            end
            5'd27: begin
                c = '0; sched.push_back(c);
            end
            default: begin
                c = '0; c.illegal = 1; sched.push_back(c);
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        logic [4:0]  op;
        int k;
        r = $urandom;
        k = int'($urandom_range(0, 15));
        if (k < 8)        op = 5'(3 + k);
        else if (k == 8)  op = 5'd15;
        else if (k == 9)  op = 5'd16;
        else if (k == 10) op = 5'd17;
        else if (k == 11) op = 5'd18;
        else if (k == 12) op = 5'd27;
        else              op = r[31:27] ^ 5'(k);
        return {op, r[26:0]};
    endfunction

    function automatic void start_instr();
        cur_ir = (directed.size() > 0) ? directed.pop_front() : rand_ir();
        cur_is_halt = (cur_ir[31:27] == 5'd27);
        build(cur_ir);
        idx = 0;
        mode = 1;
        n_instr++;
    endfunction

    initial begin
        ctl_t want;
        ctl_t halt_pat;
        logic do_rst;
        logic t4_rst_done;
        halt_pat = '0;
        halt_pat.halted = 1'b1;
        t4_rst_done = 1'b0;
        directed = '{32'h3A1B8000, 32'h781B8000, 32'h91280000, 32'hF8000000, 32'hD8000000};
        mode = 0; idx = 0; halt_cycles = 0; n_instr = 0;
        cur_ir = '0; cur_is_halt = 1'b0;

        #2 clr = 1'b0;
        #1 chk("reset_async", 64'(observe()), 64'(ctl_t'('0)));
        @(posedge clk);
        @(posedge clk);
        #3 clr = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            IR = (mode == 1 && idx >= 3) ? cur_ir : $urandom;
            if (n_instr <= 4 && mode != 2)
                run = !(mode == 1 && cur_ir == 32'hF8000000);
            else
                run = ($urandom_range(0, 3) != 0);
            #1;
            want = (mode == 1) ? sched[idx] : ((mode == 2) ? halt_pat : ctl_t'('0));
            chk($sformatf("cyc%0d_mode%0d_step%0d_ir%h", cyc, mode, idx, IR),
                64'(observe()), 64'(want));
            chk("bus_exclusive",
                64'($countones({R_wrt, PC_out, MDR_out, Zhi_out, Zlo_out, HI_out, LO_out}) <= 1),
                64'(1));

            do_rst = 1'b0;
            if (mode == 1 && !t4_rst_done && n_instr > 5 && idx == 4 && sched.size() >= 6) begin
                do_rst = 1'b1;
                t4_rst_done = 1'b1;
            end else if (mode == 2 && halt_cycles >= 4) begin
                do_rst = 1'b1;
            end else if (mode == 1 && $urandom_range(0, 299) == 0) begin
                do_rst = 1'b1;
            end
            if (do_rst) begin
                #1 clr = 1'b0;
                #1 chk($sformatf("reset_mid_cyc%0d", cyc), 64'(observe()), 64'(ctl_t'('0)));
                #2 clr = 1'b1;
                mode = 0;
            end

            case (mode)
                1: begin
                    idx++;
                    if (idx == sched.size()) begin
                        if (cur_is_halt) begin
                            mode = 2;
                            halt_cycles = 0;
                        end else if (run) begin
                            start_instr();
                        end else begin
                            mode = 0;
                        end
                    end
                end
                2: halt_cycles++;
                default: if (run) start_instr();
            endcase
        end

        chk("t4_reset_exercised", 64'(t4_rst_done), 64'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
